// File: rtl/mca_pkg.sv
// Shared definitions for the multicycle adder: FSM state encoding and default widths.
package mca_pkg;

  localparam int MCA_DATA_WIDTH  = 16;
  localparam int MCA_CHUNK_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } mca_state_e;

endpackage

// File: rtl/carry_ripple_adder.sv
// Combinational ripple-carry adder of CRA_BIT_NUMB bits with carry in and carry out.
module carry_ripple_adder #(
  parameter int CRA_BIT_NUMB = 4
) (
  input  logic [CRA_BIT_NUMB-1:0] a_i,
  input  logic [CRA_BIT_NUMB-1:0] b_i,
  input  logic                    c_i,
  output logic [CRA_BIT_NUMB-1:0] s_o,
  output logic                    c_o
);

  logic [CRA_BIT_NUMB:0] c;

  assign c[0] = c_i;

  for (genvar i = 0; i < CRA_BIT_NUMB; i++) begin : g_bit
    assign s_o[i]   = a_i[i] ^ b_i[i] ^ c[i];
    assign c[i+1]   = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
  end

  assign c_o = c[CRA_BIT_NUMB];

endmodule

// File: rtl/multicycle_adder.sv
// Adds/subtracts two DATA_WIDTH operands CHUNK_WIDTH bits per cycle with valid/ready handshakes.
// Define MULTICYCLE_ADDER_FLAGS_EN to compute zero_o and ovf_o; otherwise both are tied to 0.
module multicycle_adder
  import mca_pkg::*;
#(
  parameter int DATA_WIDTH  = MCA_DATA_WIDTH,
  parameter int CHUNK_WIDTH = MCA_CHUNK_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  input  logic                  carry_i,
  input  logic                  sub_i,
  output logic [DATA_WIDTH-1:0] sum_o,
  output logic                  carry_o,
  output logic                  zero_o,
  output logic                  ovf_o,
  output logic                  out_valid_o,
  input  logic                  out_ready_i
);

  localparam int N     = DATA_WIDTH / CHUNK_WIDTH;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

  if ((DATA_WIDTH % CHUNK_WIDTH) != 0 || DATA_WIDTH < CHUNK_WIDTH) begin : g_bad_width
    $error("multicycle_adder: DATA_WIDTH must be a positive multiple of CHUNK_WIDTH");
  end

  mca_state_e            state_q;
  logic [CNT_W-1:0]      cnt_q;
  logic                  cin_q;
  logic [DATA_WIDTH-1:0] a_q, b_q;
  logic [DATA_WIDTH-1:0] acc_q, acc_d;
  logic [DATA_WIDTH-1:0] sum_q;
  logic                  carry_q;

  logic [CHUNK_WIDTH-1:0] a_chunk, b_chunk, s_chunk;
  logic                   c_chunk;

  assign a_chunk = a_q[cnt_q*CHUNK_WIDTH +: CHUNK_WIDTH];
  assign b_chunk = b_q[cnt_q*CHUNK_WIDTH +: CHUNK_WIDTH];

  carry_ripple_adder #(
    .CRA_BIT_NUMB(CHUNK_WIDTH)
  ) u_chunk_adder (
    .a_i(a_chunk),
    .b_i(b_chunk),
    .c_i(cin_q),
    .s_o(s_chunk),
    .c_o(c_chunk)
  );

  always_comb begin
    acc_d = acc_q;
    acc_d[cnt_q*CHUNK_WIDTH +: CHUNK_WIDTH] = s_chunk;
  end

  // Operand and working-sum registers carry no reset; only control and outputs do.
  always_ff @(posedge clk_i) begin
    if (state_q == IDLE && in_valid_i) begin
      a_q <= a_i;
      b_q <= sub_i ? ~b_i : b_i;
    end
    if (state_q == CALC) begin
      acc_q <= acc_d;
    end
  end

`ifdef MULTICYCLE_ADDER_FLAGS_EN
  logic zero_q, ovf_q;
  // Carry into the MSB is recovered from the MSB sum bit and its two operand bits.
  logic msb_cin;
  assign msb_cin = s_chunk[CHUNK_WIDTH-1] ^ a_q[DATA_WIDTH-1] ^ b_q[DATA_WIDTH-1];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      zero_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else if (state_q == CALC && cnt_q == LAST) begin
      zero_q <= (acc_d == '0);
      ovf_q  <= msb_cin ^ c_chunk;
    end
  end

  assign zero_o = zero_q;
  assign ovf_o  = ovf_q;
`else
  assign zero_o = 1'b0;
  assign ovf_o  = 1'b0;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      cin_q   <= 1'b0;
      sum_q   <= '0;
      carry_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid_i) begin
            cin_q   <= sub_i ? 1'b1 : carry_i;
            cnt_q   <= '0;
            state_q <= CALC;
          end
        end
        CALC: begin
          cin_q <= c_chunk;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            sum_q   <= acc_d;
            carry_q <= c_chunk;
            state_q <= DONE;
          end
        end
        DONE: begin
          if (out_ready_i) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready_o  = (state_q == IDLE);
  assign out_valid_o = (state_q == DONE);
  assign sum_o       = sum_q;
  assign carry_o     = carry_q;

endmodule

// File: doc/multicycle_adder.md
MULTICYCLE_ADDER -- requirements
Module: multicycle_adder

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, operand/result width in bits.
REQ-002 SHALL have parameter CHUNK_WIDTH, default 4, bits added per clock cycle.
REQ-003 SHALL have port clk_i  input  1  sole clock, all state updates on rising edge.
REQ-004 SHALL have port rst_i  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port in_valid_i  input  1  operands and mode present.
REQ-006 SHALL have port in_ready_o  output  1  block can accept operands.
REQ-007 SHALL have port a_i  input  DATA_WIDTH  operand A.
REQ-008 SHALL have port b_i  input  DATA_WIDTH  operand B.
REQ-009 SHALL have port carry_i  input  1  carry-in, add mode only.
REQ-010 SHALL have port sub_i  input  1  0 = A+B+carry_i, 1 = A-B.
REQ-011 SHALL have port sum_o  output  DATA_WIDTH  result.
REQ-012 SHALL have port carry_o  output  1  carry out of MSB; in subtract mode 1 = no borrow.
REQ-013 SHALL have port zero_o  output  1  result equals zero.
REQ-014 SHALL have port ovf_o  output  1  two's-complement signed overflow.
REQ-015 SHALL have port out_valid_o  output  1  result valid.
REQ-016 SHALL have port out_ready_i  input  1  consumer takes result.

Function
REQ-017 SHALL require DATA_WIDTH to be an integer multiple of CHUNK_WIDTH; N = DATA_WIDTH/CHUNK_WIDTH; elaboration SHALL fail otherwise.
REQ-018 SHALL implement FSM IDLE -> CALC -> DONE -> IDLE.
REQ-019 IDLE: in_ready_o=1; on in_valid_i=1, capture a_i, b_i (inverted if sub_i=1), initial carry (carry_i if add, 1 if sub); chunk counter cleared; go to CALC.
REQ-020 CALC: each cycle add chunk k of captured A and B plus stored carry, write chunk k of sum register, store chunk carry, increment k; after chunk N-1 go to DONE.
REQ-021 out_valid_o SHALL rise exactly N rising edges after the accepting edge (N=4 with defaults).
REQ-022 DONE: out_valid_o=1, outputs stable; on out_ready_i=1 go to IDLE; in_ready_o=0 in CALC and DONE, so a simultaneous in_valid_i is accepted no earlier than the next cycle.
REQ-023 carry_o SHALL equal carry out of chunk N-1; ovf_o SHALL equal carry-in XOR carry-out of bit DATA_WIDTH-1; zero_o SHALL be 1 iff sum_o is all zero.
REQ-024 Result SHALL be modulo 2^DATA_WIDTH; sum_o, carry_o, zero_o, ovf_o SHALL only be meaningful while out_valid_o=1 and hold last values otherwise.
REQ-025 Operand changes after acceptance SHALL have no effect on the result in progress.

Reset
REQ-026 rst_i=1 SHALL immediately force IDLE, counter 0, sum_o 0, carry_o 0, zero_o 0, ovf_o 0, out_valid_o 0, in_ready_o 1 after release.
REQ-027 Reset during CALC or DONE SHALL abort the operation with no result produced.

Configuration
REQ-028 Macro MULTICYCLE_ADDER_FLAGS_EN defined: zero_o and ovf_o computed per REQ-023.
REQ-029 Macro not defined: zero_o and ovf_o SHALL be tied to 0, flag logic absent; sum_o/carry_o unchanged.

Structure
REQ-030 Shared package mca_pkg SHALL hold FSM state encodings (IDLE, CALC, DONE) and default DATA_WIDTH/CHUNK_WIDTH constants.
REQ-031 The per-chunk adder SHALL be one instance of the existing carry_ripple_adder with CRA_BIT_NUMB=CHUNK_WIDTH.

Verification (DATA_WIDTH=16, CHUNK_WIDTH=4)
REQ-032 Add 0x0001+0x0002, carry_i=0 -> after 4 cycles sum 0x0003, carry 0, zero 0, ovf 0.
REQ-033 Add 0xFFFF+0x0001 -> sum 0x0000, carry 1, zero 1 (flags-on build), ovf 0.
REQ-034 Sub 0x8000-0x0001 -> sum 0x7FFF, carry 1, ovf 1; flags-off build ovf 0.
REQ-035 Hold out_ready_i=0 for 5 cycles in DONE with in_valid_i=1 -> result stable, in_ready_o 0, no new accept until cycle after out_ready_i=1.
REQ-036 Assert rst_i at CALC chunk 2 -> out_valid_o never rises, all outputs 0, next operation 0x1234+0x1111 yields 0x2345.
